sb_dispatch_sched: RTL and testbench

Scheduler that sequences the per-TID register scoreboard for one CGRA block dispatch. It accepts a block (active-thread mask plus input register bitmap) and scans pending TIDs in circular order. For each TID it drives the scoreboard read port, issues the TID to the CGRA when there is no collision, and reserves that TID's registers on the same cycle. It also arbitrates two write-back sources (two LSU ports) onto the scoreboard's single release port.

---
 rtl/sb_sched_pkg.sv | 19 +
 rtl/sb_rr_pick.sv | 31 +++
 rtl/sb_dispatch_sched.sv | 154 +++++++++++++++
 tb/tb_sb_dispatch_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_sched_pkg.sv
// Shared types and sizes for the block-dispatch scoreboard scheduler.
package sb_sched_pkg;

    localparam int NUM_TID = 256;
    localparam int TID_W   = 8;
    localparam int NREG    = 34;
    localparam int REG_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    typedef logic [TID_W-1:0]   tid_t;
    typedef logic [NREG-1:0]    regmap_t;
    typedef logic [NUM_TID-1:0] tidmask_t;

endpackage

// File: rtl/sb_rr_pick.sv
// Circular first-set finder: lowest set bit of mask at index >= start, wrapping to 0.
module sb_rr_pick
    import sb_sched_pkg::*;
(
    input  logic [NUM_TID-1:0] mask,
    input  logic [TID_W-1:0]   start,
    output logic               found,
    output logic [TID_W-1:0]   idx
);

    logic [2*NUM_TID-1:0] dbl_mask;
    logic [2*NUM_TID-1:0] shifted;
    tidmask_t             rotated;
    tid_t                 offset;

    // Shifting the doubled mask right by start rotates the wrap-around into the low half.
    assign dbl_mask = {mask, mask};
    assign shifted  = dbl_mask >> start;
    assign rotated  = shifted[NUM_TID-1:0];
    assign found    = |mask;

    always_comb begin
        offset = '0;
        for (int i = NUM_TID - 1; i >= 0; i--) begin
            if (rotated[i]) offset = tid_t'(i);
        end
    end

    assign idx = start + offset;

endmodule

// File: rtl/sb_dispatch_sched.sv
// Block dispatch scheduler: circular TID scan against the register scoreboard plus write-back arbitration.
// Optional SB_SCHED_STATS_EN adds saturating issue/collision counters.
module sb_dispatch_sched
    import sb_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blk_start_valid,
    output logic                blk_start_ready,
    input  logic [NUM_TID-1:0]  blk_active_mask,
    input  logic [NREG-1:0]     blk_regs_map,
    output logic                blk_done,
    output logic [NREG-1:0]     sb_regs_map,
    output logic [TID_W-1:0]    sb_rd_tid,
    output logic                sb_rd_valid,
    input  logic                sb_collision,
    output logic [TID_W-1:0]    sb_rsv_tid,
    output logic                sb_rsv_valid,
    output logic                issue_valid,
    output logic [TID_W-1:0]    issue_tid,
    input  logic                issue_ready,
    input  logic                wb0_valid,
    output logic                wb0_ready,
    input  logic [NUM_TID-1:0]  wb0_tid_bitmap,
    input  logic [REG_W-1:0]    wb0_dest_reg,
    input  logic                wb1_valid,
    output logic                wb1_ready,
    input  logic [NUM_TID-1:0]  wb1_tid_bitmap,
    input  logic [REG_W-1:0]    wb1_dest_reg,
    output logic                sb_wb_valid,
    output logic [NUM_TID-1:0]  sb_wb_tid_bitmap,
    output logic [REG_W-1:0]    sb_wb_dest_reg,
    output logic [31:0]         stat_issued,
    output logic [31:0]         stat_collision
);

    sched_state_e state_reg, state_next;
    tidmask_t     pending_reg, pending_next;
    tid_t         ptr_reg, ptr_next;
    regmap_t      regs_map_reg;
    logic         rr_reg;

    logic         cand_found;
    tid_t         cand;
    logic         fire;

    sb_rr_pick u_pick (
        .mask  (pending_reg),
        .start (ptr_reg),
        .found (cand_found),
        .idx   (cand)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            ptr_reg      <= '0;
            regs_map_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            ptr_reg     <= ptr_next;
            if (state_reg == IDLE && blk_start_valid) regs_map_reg <= blk_regs_map;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pending_next    = pending_reg;
        ptr_next        = ptr_reg;
        blk_start_ready = 1'b0;
        blk_done        = 1'b0;
        sb_rd_valid     = 1'b0;
        sb_rd_tid       = '0;
        issue_valid     = 1'b0;
        issue_tid       = '0;
        sb_rsv_valid    = 1'b0;
        sb_rsv_tid      = '0;
        fire            = 1'b0;
        case (state_reg)
            IDLE: begin
                blk_start_ready = 1'b1;
                if (blk_start_valid) begin
                    pending_next = blk_active_mask;
                    ptr_next     = '0;
                    state_next   = (blk_active_mask == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (cand_found) begin
                    sb_rd_valid = 1'b1;
                    sb_rd_tid   = cand;
                    issue_valid = !sb_collision;
                    issue_tid   = cand;
                    fire        = !sb_collision && issue_ready;
                    // Advance past cand even when blocked so later TIDs get their turn.
                    ptr_next    = cand + tid_t'(1);
                    if (fire) begin
                        sb_rsv_valid       = 1'b1;
                        sb_rsv_tid         = cand;
                        pending_next[cand] = 1'b0;
                    end
                end
                if (pending_next == '0) state_next = DONE;
            end
            DONE: begin
                blk_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sb_regs_map = (state_reg == IDLE) ? '0 : regs_map_reg;

    // Write-back arbiter: rr only matters, and only flips, when both sources contend.
    logic grant0, grant1;
    assign grant0 = wb0_valid && (!wb1_valid || !rr_reg);
    assign grant1 = wb1_valid && (!wb0_valid ||  rr_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       rr_reg <= 1'b0;
        else if (wb0_valid && wb1_valid)  rr_reg <= !rr_reg;
    end

    assign wb0_ready        = grant0;
    assign wb1_ready        = grant1;
    assign sb_wb_valid      = wb0_valid | wb1_valid;
    assign sb_wb_tid_bitmap = grant0 ? wb0_tid_bitmap : (grant1 ? wb1_tid_bitmap : '0);
    assign sb_wb_dest_reg   = grant0 ? wb0_dest_reg   : (grant1 ? wb1_dest_reg   : '0);

`ifdef SB_SCHED_STATS_EN
    logic [31:0] issued_reg, collision_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_reg    <= '0;
            collision_reg <= '0;
        end else begin
            if (fire && issued_reg != '1) issued_reg <= issued_reg + 32'd1;
            if (sb_rd_valid && sb_collision && collision_reg != '1)
                collision_reg <= collision_reg + 32'd1;
        end
    end

    assign stat_issued    = issued_reg;
    assign stat_collision = collision_reg;
`else
    assign stat_issued    = '0;
    assign stat_collision = '0;
`endif

endmodule

// File: tb/tb_sb_dispatch_sched.sv
// Self-checking bench for sb_dispatch_sched: per-cycle model comparison plus directed literal checks.
module tb_sb_dispatch_sched;
    import sb_sched_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                blk_start_valid, blk_start_ready, blk_done;
    logic [NUM_TID-1:0]  blk_active_mask;
    logic [NREG-1:0]     blk_regs_map, sb_regs_map;
    logic [TID_W-1:0]    sb_rd_tid, sb_rsv_tid, issue_tid;
    logic                sb_rd_valid, sb_collision, sb_rsv_valid, issue_valid, issue_ready;
    logic                wb0_valid, wb0_ready, wb1_valid, wb1_ready, sb_wb_valid;
    logic [NUM_TID-1:0]  wb0_tid_bitmap, wb1_tid_bitmap, sb_wb_tid_bitmap;
    logic [REG_W-1:0]    wb0_dest_reg, wb1_dest_reg, sb_wb_dest_reg;
    logic [31:0]         stat_issued, stat_collision;

    logic                coll_en;
    logic [TID_W-1:0]    coll_tid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Scoreboard stand-in: collide whenever the checked TID is the forced one.
    assign sb_collision = coll_en && sb_rd_valid && (sb_rd_tid == coll_tid);

    sb_dispatch_sched dut (
        .clk(clk), .rst_n(rst_n),
        .blk_start_valid(blk_start_valid), .blk_start_ready(blk_start_ready),
        .blk_active_mask(blk_active_mask), .blk_regs_map(blk_regs_map),
        .blk_done(blk_done), .sb_regs_map(sb_regs_map),
        .sb_rd_tid(sb_rd_tid), .sb_rd_valid(sb_rd_valid), .sb_collision(sb_collision),
        .sb_rsv_tid(sb_rsv_tid), .sb_rsv_valid(sb_rsv_valid),
        .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_ready(issue_ready),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready),
        .wb0_tid_bitmap(wb0_tid_bitmap), .wb0_dest_reg(wb0_dest_reg),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready),
        .wb1_tid_bitmap(wb1_tid_bitmap), .wb1_dest_reg(wb1_dest_reg),
        .sb_wb_valid(sb_wb_valid), .sb_wb_tid_bitmap(sb_wb_tid_bitmap),
        .sb_wb_dest_reg(sb_wb_dest_reg),
        .stat_issued(stat_issued), .stat_collision(stat_collision)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_phase;      // 0 idle, 1 scanning, 2 done pulse
    logic [255:0] m_pend;
    int           m_ptr;
    logic [33:0]  m_map;
    bit           m_rr;
    logic [31:0]  m_iss, m_col;

    function automatic int find_cand(input logic [255:0] p, input int start);
        for (int i = 0; i < 256; i++) begin
            int k;
            k = (start + i) % 256;
            if (p[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pend = '0; m_ptr = 0; m_map = '0; m_rr = 0; m_iss = 0; m_col = 0;
    endtask

    task automatic model_step();
        int  c;
        bit  coll, go;
        if (wb0_valid && wb1_valid) m_rr = !m_rr;
        if (m_phase == 0) begin
            if (blk_start_valid) begin
                m_pend = blk_active_mask; m_map = blk_regs_map; m_ptr = 0;
                m_phase = (blk_active_mask == '0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            c = find_cand(m_pend, m_ptr);
            if (c >= 0) begin
                coll = coll_en && (c == int'(coll_tid));
                go   = !coll && issue_ready;
                if (go && m_iss != 32'hFFFF_FFFF) m_iss = m_iss + 1;
                if (coll && m_col != 32'hFFFF_FFFF) m_col = m_col + 1;
                m_ptr = (c + 1) % 256;
                if (go) m_pend[c] = 1'b0;
            end
            if (m_pend == '0) m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle compare + event log ----------------
    int ncyc = 0;
    int last_start = 0;
    int iss_tid[$], iss_cyc[$], done_cyc[$], wb_grant[$], wb_dest[$];
    logic [255:0] wb_bm[$];

    always @(negedge clk) begin
        int  c;
        bit  rv, coll, iv, go, g0, g1;
        ncyc++;
        c    = (m_phase == 1) ? find_cand(m_pend, m_ptr) : -1;
        rv   = (c >= 0);
        coll = rv && coll_en && (c == int'(coll_tid));
        iv   = rv && !coll;
        go   = iv && issue_ready;
        g0   = wb0_valid && (!wb1_valid || !m_rr);
        g1   = wb1_valid && (!wb0_valid || m_rr);
        chk("start_ready", 256'(blk_start_ready), 256'(m_phase == 0));
        chk("blk_done", 256'(blk_done), 256'(m_phase == 2));
        chk("regs_map", 256'(sb_regs_map), (m_phase == 0) ? 256'(0) : 256'(m_map));
        chk("rd_valid", 256'(sb_rd_valid), 256'(rv));
        chk("rd_tid", 256'(sb_rd_tid), rv ? 256'(c) : 256'(0));
        chk("issue_valid", 256'(issue_valid), 256'(iv));
        chk("issue_tid", 256'(issue_tid), rv ? 256'(c) : 256'(0));
        chk("rsv_valid", 256'(sb_rsv_valid), 256'(go));
        chk("rsv_tid", 256'(sb_rsv_tid), go ? 256'(c) : 256'(0));
        chk("wb_valid", 256'(sb_wb_valid), 256'(wb0_valid | wb1_valid));
        chk("wb0_ready", 256'(wb0_ready), 256'(g0));
        chk("wb1_ready", 256'(wb1_ready), 256'(g1));
        chk("wb_bitmap", sb_wb_tid_bitmap, g0 ? wb0_tid_bitmap : (g1 ? wb1_tid_bitmap : 256'(0)));
        chk("wb_dest", 256'(sb_wb_dest_reg), g0 ? 256'(wb0_dest_reg) : (g1 ? 256'(wb1_dest_reg) : 256'(0)));
`ifdef SB_SCHED_STATS_EN
        chk("stat_issued", 256'(stat_issued), 256'(m_iss));
        chk("stat_collision", 256'(stat_collision), 256'(m_col));
`else
        chk("stat_issued", 256'(stat_issued), 256'(0));
        chk("stat_collision", 256'(stat_collision), 256'(0));
`endif
        if (blk_start_valid && blk_start_ready) last_start = ncyc;
        if (issue_valid && issue_ready) begin
            iss_tid.push_back(int'(issue_tid));
            iss_cyc.push_back(ncyc);
            $display("issue tid=%0d cyc=%0d", issue_tid, ncyc);
        end
        if (blk_done) begin
            done_cyc.push_back(ncyc);
            $display("blk_done cyc=%0d", ncyc);
        end
        if (sb_wb_valid) begin
            wb_grant.push_back(wb1_ready ? 1 : 0);
            wb_bm.push_back(sb_wb_tid_bitmap);
            wb_dest.push_back(int'(sb_wb_dest_reg));
            $display("wb grant=%0d dest=%0d", wb1_ready ? 1 : 0, sb_wb_dest_reg);
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_block(input logic [255:0] mask, input logic [33:0] map);
        @(posedge clk); #1;
        blk_start_valid = 1'b1; blk_active_mask = mask; blk_regs_map = map;
        @(posedge clk); #1;
        blk_start_valid = 1'b0; blk_active_mask = '0; blk_regs_map = '0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        int d0;
        n = 0;
        d0 = done_cyc.size();
        while (done_cyc.size() == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cyc.size() == d0) begin
            failures++;
            $display("FAIL wait_done actual=timeout required=blk_done within %0d cycles", limit);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int d;
        blk_start_valid = 0; blk_active_mask = '0; blk_regs_map = '0;
        issue_ready = 1; coll_en = 0; coll_tid = '0;
        wb0_valid = 0; wb1_valid = 0; wb0_tid_bitmap = '0; wb1_tid_bitmap = '0;
        wb0_dest_reg = '0; wb1_dest_reg = '0;
        repeat (3) @(posedge clk);
        chk("reset_ready", 256'(blk_start_ready), 256'(1));
        chk("reset_rd_valid", 256'(sb_rd_valid), 256'(0));
        #1 rst_n = 1;

        // 1: four TIDs issue back to back, done the cycle after the last
        b = iss_tid.size();
        start_block(256'h0F, 34'h3);
        wait_done(50);
        chk("t1_count", 256'(iss_tid.size() - b), 256'(4));
        if (iss_tid.size() >= b + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_tid", 256'(iss_tid[b+i]), 256'(i));
                chk("t1_cyc", 256'(iss_cyc[b+i] - last_start), 256'(i + 1));
            end
        end
        chk("t1_done_cyc", 256'(done_cyc[done_cyc.size()-1] - last_start), 256'(5));

        // 2: TID 5 collides three times, 9 overtakes it
        b = iss_tid.size();
        coll_tid = 8'd5; coll_en = 1;
        start_block((256'd1 << 5) | (256'd1 << 9), 34'h2_0000_0001);
        repeat (4) @(posedge clk);
        #1 coll_en = 0;
        wait_done(50);
        chk("t2_count", 256'(iss_tid.size() - b), 256'(2));
        if (iss_tid.size() >= b + 2) begin
            chk("t2_first", 256'(iss_tid[b]), 256'(9));
            chk("t2_second", 256'(iss_tid[b+1]), 256'(5));
            chk("t2_first_cyc", 256'(iss_cyc[b] - last_start), 256'(2));
            chk("t2_second_cyc", 256'(iss_cyc[b+1] - last_start), 256'(5));
        end

        // 3: top TID, then TID 0 on a fresh block
        b = iss_tid.size();
        start_block(256'd1 << 255, 34'h1);
        wait_done(50);
        start_block(256'd1, 34'h1);
        wait_done(50);
        chk("t3_count", 256'(iss_tid.size() - b), 256'(2));
        if (iss_tid.size() >= b + 2) begin
            chk("t3_tid255", 256'(iss_tid[b]), 256'(255));
            chk("t3_tid0", 256'(iss_tid[b+1]), 256'(0));
            chk("t3_cyc", 256'(iss_cyc[b+1] - last_start), 256'(1));
        end

        // 4: CGRA back-pressure for four cycles
        b = iss_tid.size();
        issue_ready = 0;
        start_block(256'd1 << 2, 34'h4);
        repeat (4) @(posedge clk);
        #1 issue_ready = 1;
        wait_done(50);
        chk("t4_count", 256'(iss_tid.size() - b), 256'(1));
        if (iss_tid.size() >= b + 1) begin
            chk("t4_tid", 256'(iss_tid[b]), 256'(2));
            chk("t4_cyc", 256'(iss_cyc[b] - last_start), 256'(5));
        end

        // 5: both write-back sources contend for three cycles
        b = wb_grant.size();
        @(posedge clk); #1;
        wb0_valid = 1; wb0_tid_bitmap = 256'hA5; wb0_dest_reg = 7'd7;
        wb1_valid = 1; wb1_tid_bitmap = 256'd1 << 200; wb1_dest_reg = 7'd33;
        repeat (3) @(posedge clk);
        #1 wb0_valid = 0; wb1_valid = 0;
        @(posedge clk); #1;
        chk("t5_count", 256'(wb_grant.size() - b), 256'(3));
        if (wb_grant.size() >= b + 3) begin
            chk("t5_g0", 256'(wb_grant[b]), 256'(0));
            chk("t5_g1", 256'(wb_grant[b+1]), 256'(1));
            chk("t5_g2", 256'(wb_grant[b+2]), 256'(0));
            chk("t5_bm1", wb_bm[b+1], 256'd1 << 200);
            chk("t5_dest0", 256'(wb_dest[b]), 256'(7));
            chk("t5_dest1", 256'(wb_dest[b+1]), 256'(33));
        end

        // 6: asynchronous reset in the middle of a scan
        start_block(256'hFF, 34'h3_FFFF_FFFF);
        repeat (2) @(posedge clk);
        d = done_cyc.size();
        #1 rst_n = 0;
        #1;
        chk("t6_rd_valid", 256'(sb_rd_valid), 256'(0));
        chk("t6_issue_valid", 256'(issue_valid), 256'(0));
        chk("t6_rsv_valid", 256'(sb_rsv_valid), 256'(0));
        chk("t6_regs_map", 256'(sb_regs_map), 256'(0));
        chk("t6_ready", 256'(blk_start_ready), 256'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(posedge clk);
        chk("t6_no_done", 256'(done_cyc.size()), 256'(d));
        b = iss_tid.size();
        start_block(256'h0F, 34'h3);
        wait_done(50);
        chk("t6_after_count", 256'(iss_tid.size() - b), 256'(4));
        if (iss_tid.size() >= b + 4) chk("t6_after_last", 256'(iss_tid[b+3]), 256'(3));

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
